// File: rtl/sc_intc_pkg.sv
// Shared definitions for the sc_intc interrupt controller: register offsets,
// controller states and the id-width helper.
package sc_intc_pkg;

    localparam logic [3:0] INTC_PEND = 4'h0;
    localparam logic [3:0] INTC_MASK = 4'h4;
    localparam logic [3:0] INTC_VEC  = 4'h8;
    localparam logic [3:0] INTC_EOI  = 4'hC;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } intc_state_e;

    // Width of the latched source id; clamp to 1 so N_SRC=1 still elaborates.
    function automatic int id_width(input int n_src);
        return (n_src > 1) ? $clog2(n_src) : 1;
    endfunction

endpackage

// File: rtl/sc_intc_prio.sv
// Combinational lowest-index priority encoder: index 0 wins.
module sc_intc_prio
    import sc_intc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = id_width(N)
) (
    input  logic [N-1:0] req_i,
    output logic         any_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        // Scan downwards so the lowest set index is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

endmodule

// File: rtl/sc_intc.sv
// Interrupt controller with pending/mask/vector/EOI registers on the CPU data bus.
// Define SC_INTC_EDGE_EN for rising-edge sources; otherwise sources are level-sensitive.
module sc_intc
    import sc_intc_pkg::*;
#(
    parameter int          N_SRC = 8,
    parameter logic [31:0] BASE  = 32'h0000_FF00
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_SRC-1:0] irq,
    output logic             intr,
    input  logic             inta,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             we,
    output logic             sel,
    output logic [31:0]      rdata
);

    localparam int IDW = id_width(N_SRC);

    intc_state_e      state_q, state_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             intr_q, intr_d;

    logic [N_SRC-1:0] set;
    logic [N_SRC-1:0] act;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] wr_clr;
    logic             act_any;
    logic [IDW-1:0]   act_idx;
    logic [3:0]       off;
    logic             wr_en, wr_pend, wr_mask, wr_eoi;
    logic             ack;
    logic             busy;
    logic             unused_bits;

    // Upper write-data bits and the byte lane are don't-care for this register file.
    assign unused_bits = ^{wdata, addr[1:0]};

    assign sel     = (addr[31:4] == BASE[31:4]);
    assign off     = {addr[3:2], 2'b00};
    assign wr_en   = we & sel;
    assign wr_pend = wr_en && (off == INTC_PEND);
    assign wr_mask = wr_en && (off == INTC_MASK);
    assign wr_eoi  = wr_en && (off == INTC_EOI);

    assign busy = (state_q == ST_SERVICE);
    assign intr = intr_q;
    assign act  = pend_q & mask_q;

    sc_intc_prio #(
        .N (N_SRC),
        .W (IDW)
    ) u_prio (
        .req_i (act),
        .any_o (act_any),
        .idx_o (act_idx)
    );

`ifdef SC_INTC_EDGE_EN
    logic [N_SRC-1:0] irq_q;

    // Follows irq through reset too, so a line held across reset gives no edge.
    always_ff @(posedge clk) begin
        irq_q <= irq;
    end

    assign set = irq & ~irq_q;
`else
    assign set = irq;
`endif

    assign ack    = (state_q == ST_IDLE) && inta && act_any;
    assign wr_clr = wr_pend ? wdata[N_SRC-1:0] : '0;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ack_clr
        assign ack_clr[gi] = ack && (act_idx == IDW'(gi));
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        intr_d  = 1'b0;
        mask_d  = wr_mask ? wdata[N_SRC-1:0] : mask_q;
        // New requests override any clear landing on the same bit.
        pend_d  = (pend_q & ~(wr_clr | ack_clr)) | set;

        case (state_q)
            ST_IDLE: begin
                intr_d = act_any;
                if (inta) begin
                    if (act_any) begin
                        id_d    = act_idx;
                        state_d = ST_SERVICE;
                        intr_d  = 1'b0;
                    end else begin
                        id_d = IDW'(N_SRC - 1);
                    end
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            mask_q  <= '0;
            id_q    <= '0;
            intr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            id_q    <= id_d;
            intr_q  <= intr_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                INTC_PEND: rdata = 32'(pend_q);
                INTC_MASK: rdata = 32'(mask_q);
                INTC_VEC:  rdata = {busy, 26'b0, 5'(id_q)};
                default:   rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_intc.sv
// Self-checking bench for sc_intc: a per-cycle vector table plus hand-written
// reset and bus-decode sequences, with expectations routed through a scoreboard.
module tb_sc_intc;

    localparam logic [31:0] BASE = 32'h0000_FF00;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [7:0]  irq = '0;
    logic        intr;
    logic        inta = 1'b0;
    logic [31:0] addr = BASE;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        sel;
    logic [31:0] rdata;

    sc_intc #(
        .N_SRC (8),
        .BASE  (BASE)
    ) dut (
        .clk   (clk),
        .clr   (clr),
        .irq   (irq),
        .intr  (intr),
        .inta  (inta),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .sel   (sel),
        .rdata (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  irq;
        bit          inta;
        bit          we;
        logic [3:0]  woff;
        logic [31:0] wd;
        logic [3:0]  roff;
        bit          exp_intr;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(string nm, logic [7:0] i, bit a, bit w, logic [3:0] wo,
                                logic [31:0] wd, logic [3:0] ro, bit ei, logic [31:0] er);
        vec_t v;
        v.name = nm; v.irq = i; v.inta = a; v.we = w; v.woff = wo; v.wd = wd;
        v.roff = ro; v.exp_intr = ei; v.exp_rd = er;
        return v;
    endfunction

    task automatic expect_val(input string nm, input logic [31:0] e);
        sb_t s;
        s.name = nm;
        s.exp  = e;
        sb_q.push_back(s);
    endtask

    task automatic check_next(input logic [31:0] act);
        sb_t s;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: got %h with no expected value queued", act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.name, act, s.exp);
            end else begin
                $display("ok   %s: %h", s.name, act);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] roff);
        addr = BASE + {28'b0, roff};
        #1;
    endtask

    initial begin
        // Reset state and test 1: basic request
        vecs.push_back(mk("rst_pend",    8'h00, 0, 0, 4'h0, 0,      4'h0, 0, 32'h0));
        vecs.push_back(mk("rst_mask",    8'h00, 0, 0, 4'h0, 0,      4'h4, 0, 32'h0));
        vecs.push_back(mk("rst_vec",     8'h00, 0, 0, 4'h0, 0,      4'h8, 0, 32'h0));
        vecs.push_back(mk("rst_eoi",     8'h00, 0, 0, 4'h0, 0,      4'hC, 0, 32'h0));
        vecs.push_back(mk("t1_mask",     8'h00, 0, 1, 4'h4, 32'h04, 4'h4, 0, 32'h4));
        vecs.push_back(mk("t1_irq2",     8'h04, 0, 0, 4'h0, 0,      4'h0, 0, 32'h4));
        vecs.push_back(mk("t1_intr",     8'h00, 0, 0, 4'h0, 0,      4'h0, 1, 32'h4));
        vecs.push_back(mk("t1_ack",      8'h00, 1, 0, 4'h0, 0,      4'h8, 0, 32'h8000_0002));
        vecs.push_back(mk("t1_pend0",    8'h00, 0, 0, 4'h0, 0,      4'h0, 0, 32'h0));
        vecs.push_back(mk("t1_eoi",      8'h00, 0, 1, 4'hC, 0,      4'h8, 0, 32'h2));
        vecs.push_back(mk("t1_idle",     8'h00, 0, 0, 4'h0, 0,      4'h8, 0, 32'h2));
        // Test 2: priority
        vecs.push_back(mk("t2_mask",     8'h00, 0, 1, 4'h4, 32'hFF, 4'h4, 0, 32'hFF));
        vecs.push_back(mk("t2_irq53",    8'h28, 0, 0, 4'h0, 0,      4'h0, 0, 32'h28));
        vecs.push_back(mk("t2_intr",     8'h00, 0, 0, 4'h0, 0,      4'h0, 1, 32'h28));
        vecs.push_back(mk("t2_ack3",     8'h00, 1, 0, 4'h0, 0,      4'h8, 0, 32'h8000_0003));
        vecs.push_back(mk("t2_pend20",   8'h00, 0, 0, 4'h0, 0,      4'h0, 0, 32'h20));
        vecs.push_back(mk("t2_eoi",      8'h00, 0, 1, 4'hC, 0,      4'h8, 0, 32'h3));
        vecs.push_back(mk("t2_reassert", 8'h00, 0, 0, 4'h0, 0,      4'h8, 1, 32'h3));
        vecs.push_back(mk("t2_ack5",     8'h00, 1, 0, 4'h0, 0,      4'h8, 0, 32'h8000_0005));
        vecs.push_back(mk("t2_eoi2",     8'h00, 0, 1, 4'hC, 0,      4'h0, 0, 32'h0));
        // Test 3: masking
        vecs.push_back(mk("t3_mask0",    8'h00, 0, 1, 4'h4, 32'h00, 4'h4, 0, 32'h0));
        vecs.push_back(mk("t3_irq1",     8'h02, 0, 0, 4'h0, 0,      4'h0, 0, 32'h2));
        vecs.push_back(mk("t3_hold",     8'h00, 0, 0, 4'h0, 0,      4'h0, 0, 32'h2));
        vecs.push_back(mk("t3_masked",   8'h00, 0, 0, 4'h0, 0,      4'h0, 0, 32'h2));
        vecs.push_back(mk("t3_unmask",   8'h00, 0, 1, 4'h4, 32'h02, 4'h4, 0, 32'h2));
        vecs.push_back(mk("t3_intr",     8'h00, 0, 0, 4'h0, 0,      4'h8, 1, 32'h5));
        // Test 5: acknowledge while busy is ignored
        vecs.push_back(mk("t5_ack1",     8'h00, 1, 0, 4'h0, 0,      4'h8, 0, 32'h8000_0001));
        vecs.push_back(mk("t5_irq0",     8'h01, 0, 1, 4'h4, 32'h03, 4'h0, 0, 32'h1));
        vecs.push_back(mk("t5_blocked",  8'h00, 1, 0, 4'h0, 0,      4'h8, 0, 32'h8000_0001));
        vecs.push_back(mk("t5_pend_kept",8'h00, 0, 0, 4'h0, 0,      4'h0, 0, 32'h1));
        vecs.push_back(mk("t5_eoi",      8'h00, 0, 1, 4'hC, 0,      4'h8, 0, 32'h1));
        vecs.push_back(mk("t5_reassert", 8'h00, 0, 0, 4'h0, 0,      4'h8, 1, 32'h1));
        vecs.push_back(mk("t5_ack0",     8'h00, 1, 0, 4'h0, 0,      4'h8, 0, 32'h8000_0000));
        vecs.push_back(mk("t5_eoi2",     8'h00, 0, 1, 4'hC, 0,      4'h0, 0, 32'h0));
        // Spurious acknowledge reports N_SRC-1
        vecs.push_back(mk("t5_spurious", 8'h00, 1, 0, 4'h0, 0,      4'h8, 0, 32'h7));
        vecs.push_back(mk("t5_sp_pend",  8'h00, 0, 0, 4'h0, 0,      4'h0, 0, 32'h0));
        // PEND write-1-to-clear and read-only VEC
        vecs.push_back(mk("w1c_set",     8'h04, 0, 0, 4'h0, 0,      4'h0, 0, 32'h4));
        vecs.push_back(mk("w1c_clear",   8'h00, 0, 1, 4'h0, 32'hFF, 4'h0, 0, 32'h0));
        vecs.push_back(mk("vec_ro",      8'h00, 0, 1, 4'h8, 32'hFFFF_FFFF, 4'h8, 0, 32'h7));
        // Test 4: set wins over a simultaneous write-1-to-clear
        vecs.push_back(mk("t4_set",      8'h10, 0, 0, 4'h0, 0,      4'h0, 0, 32'h10));
        vecs.push_back(mk("t4_low",      8'h00, 0, 0, 4'h0, 0,      4'h0, 0, 32'h10));
        vecs.push_back(mk("t4_setwins",  8'h10, 0, 1, 4'h0, 32'h10, 4'h0, 0, 32'h10));
        vecs.push_back(mk("t4_clear",    8'h00, 0, 1, 4'h0, 32'h10, 4'h0, 0, 32'h0));

        cycle();
        cycle();
        clr = 1'b0;

        foreach (vecs[k]) begin
            irq   = vecs[k].irq;
            inta  = vecs[k].inta;
            we    = vecs[k].we;
            addr  = BASE + {28'b0, vecs[k].woff};
            wdata = vecs[k].wd;
            expect_val({vecs[k].name, "/intr"}, {31'b0, vecs[k].exp_intr});
            expect_val({vecs[k].name, "/rd"}, vecs[k].exp_rd);
            cycle();
            inta = 1'b0;
            we   = 1'b0;
            rd(vecs[k].roff);
            check_next({31'b0, intr});
            check_next(rdata);
        end

        // Bus decode: a write just outside the window must not land
        addr  = BASE - 32'h0000_000C;
        wdata = 32'hFF;
        we    = 1'b1;
        #1;
        expect_val("dec_sel_below", 32'h0);
        check_next({31'b0, sel});
        expect_val("dec_rdata_below", 32'h0);
        check_next(rdata);
        cycle();
        we = 1'b0;
        addr = BASE + 32'h0000_0014;
        #1;
        expect_val("dec_sel_above", 32'h0);
        check_next({31'b0, sel});
        rd(4'h4);
        expect_val("dec_sel_in", 32'h1);
        check_next({31'b0, sel});
        expect_val("dec_mask_kept", 32'h3);
        check_next(rdata);

        // Test 6: reset in SERVICE with irq[0] held high
        irq   = 8'h01;
        we    = 1'b1;
        addr  = BASE + 32'h4;
        wdata = 32'h1;
        cycle();
        we = 1'b0;
        expect_val("t6_intr", 32'h1);
        cycle();
        check_next({31'b0, intr});
        inta = 1'b1;
        expect_val("t6_busy", 32'h8000_0000);
        cycle();
        inta = 1'b0;
        rd(4'h8);
        check_next(rdata);
        clr = 1'b1;
        expect_val("t6_rst_vec", 32'h0);
        expect_val("t6_rst_pend", 32'h0);
        expect_val("t6_rst_intr", 32'h0);
        cycle();
        clr = 1'b0;
        rd(4'h8);
        check_next(rdata);
        rd(4'h0);
        check_next(rdata);
        check_next({31'b0, intr});
`ifdef SC_INTC_EDGE_EN
        expect_val("t6_no_edge_pend", 32'h0);
`else
        expect_val("t6_level_pend", 32'h1);
`endif
        expect_val("t6_post_intr", 32'h0);
        cycle();
        rd(4'h0);
        check_next(rdata);
        check_next({31'b0, intr});
        irq = 8'h00;
        cycle();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
